// File: rtl/calculadora_seq.sv
// Clocked calculator: debounced push-buttons load A/B/OP from entrada, the ALU result
// and flags are registered every cycle, and accumulate mode feeds rdo back into A.
module calculadora_seq #(
    parameter int BUS     = 8,
    parameter int OP      = 6,
    parameter int DEB_CYC = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [BUS-1:0] entrada,
    input  logic           boton_a,
    input  logic           boton_b,
    input  logic           boton_op,
    input  logic           boton_acc,
    output logic [BUS-1:0] rdo,
    output logic           carry,
    output logic           zero,
    output logic           valid
);

    localparam int CW = $clog2(DEB_CYC + 1);

    typedef enum logic [5:0] {
        ALU_ADD = 6'b100000,
        ALU_SUB = 6'b100010,
        ALU_AND = 6'b100100,
        ALU_OR  = 6'b100101,
        ALU_XOR = 6'b100110,
        ALU_NOR = 6'b100111,
        ALU_SRL = 6'b000010,
        ALU_SRA = 6'b000011
    } alu_op_e;

    // Button index: 0 = a, 1 = b, 2 = op, 3 = acc
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_d;
    logic [3:0]    pulse;
    logic [CW-1:0] cnt [4];

    logic [BUS-1:0] a_r;
    logic [BUS-1:0] b_r;
    logic [OP-1:0]  op_r;
    logic           got_a;
    logic           got_b;
    logic           got_op;

    logic [5:0]     op6;
    logic [BUS:0]   sum;
    logic [BUS-1:0] res;
    logic           res_carry;

    assign raw   = {boton_acc, boton_op, boton_b, boton_a};
    assign pulse = deb & ~deb_d;
    assign valid = got_a & got_b & got_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            // The debounced level flips on the DEB_CYC-th consecutive differing sample
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CW'(DEB_CYC - 1)) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            got_a  <= 1'b0;
            got_b  <= 1'b0;
            got_op <= 1'b0;
            rdo    <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
        end else begin
            if (pulse[0]) begin
                a_r <= entrada;
            end else if (pulse[3]) begin
                a_r <= rdo;
            end
            if (pulse[1]) begin
                b_r <= entrada;
            end
            if (pulse[2]) begin
                op_r <= entrada[OP-1:0];
            end
            if (pulse[0] || pulse[3]) begin
                got_a <= 1'b1;
            end
            if (pulse[1]) begin
                got_b <= 1'b1;
            end
            if (pulse[2]) begin
                got_op <= 1'b1;
            end
            rdo   <= res;
            carry <= res_carry;
            zero  <= (res == '0);
        end
    end

    always_comb begin
        op6       = 6'(op_r);
        sum       = {1'b0, a_r} + {1'b0, b_r};
        res       = '0;
        res_carry = 1'b0;
        case (op6)
            ALU_ADD: begin
                res       = sum[BUS-1:0];
                res_carry = sum[BUS];
            end
            ALU_SUB: begin
                res       = a_r - b_r;
                res_carry = (a_r < b_r);
            end
            ALU_AND: res = a_r & b_r;
            ALU_OR:  res = a_r | b_r;
            ALU_XOR: res = a_r ^ b_r;
            ALU_NOR: res = ~(a_r | b_r);
            ALU_SRL: res = a_r >> b_r;
            ALU_SRA: res = $signed(a_r) >>> b_r;
            default: begin
                res       = '0;
                res_carry = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_calculadora_seq.sv
// Directed plus randomized bench for calculadora_seq against an arithmetic reference model.
module tb_calculadora_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] entrada;
    logic       boton_a;
    logic       boton_b;
    logic       boton_op;
    logic       boton_acc;
    logic [7:0] rdo;
    logic       carry;
    logic       zero;
    logic       valid;

    int checks   = 0;
    int failures = 0;

    int m_a, m_b, m_op;
    bit m_got_a, m_got_b, m_got_op;

    calculadora_seq #(.BUS(8), .OP(6), .DEB_CYC(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .entrada  (entrada),
        .boton_a  (boton_a),
        .boton_b  (boton_b),
        .boton_op (boton_op),
        .boton_acc(boton_acc),
        .rdo      (rdo),
        .carry    (carry),
        .zero     (zero),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU from plain integer arithmetic; returns {carry, rdo}
    function automatic int ref_alu(input int a, input int b, input int op);
        int r, c, sa, p;
        r = 0;
        c = 0;
        case (op)
            32: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            34: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = 255 - (a | b);
            2:  r = (b >= 8) ? 0 : a / (1 << b);
            3: begin
                sa = (a >= 128) ? a - 256 : a;
                if (b >= 8) begin
                    r = (sa < 0) ? 255 : 0;
                end else begin
                    p = 1 << b;
                    r = (sa >= 0) ? sa / p : (sa - (p - 1)) / p;
                    r = (r + 256) % 256;
                end
            end
            default: r = 0;
        endcase
        return c * 256 + r;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int e;
        e = ref_alu(m_a, m_b, m_op);
        check({tag, ".rdo"}, int'(rdo), e % 256);
        check({tag, ".carry"}, int'(carry), e / 256);
        check({tag, ".zero"}, int'(zero), (e % 256 == 0) ? 1 : 0);
        check({tag, ".valid"}, int'(valid), (m_got_a && m_got_b && m_got_op) ? 1 : 0);
    endtask

    task automatic model_load(input logic [3:0] m, input int val);
        int cur;
        cur = ref_alu(m_a, m_b, m_op) % 256;
        if (m[0]) m_a = val;
        else if (m[3]) m_a = cur;
        if (m[1]) m_b = val;
        if (m[2]) m_op = val % 64;
        if (m[0] || m[3]) m_got_a = 1;
        if (m[1]) m_got_b = 1;
        if (m[2]) m_got_op = 1;
    endtask

    // m: {acc, op, b, a}; clean press held long enough to load, then released
    task automatic press(input logic [3:0] m, input logic [7:0] val);
        entrada = val;
        {boton_acc, boton_op, boton_b, boton_a} = m;
        repeat (12) @(negedge clk);
        {boton_acc, boton_op, boton_b, boton_a} = 4'b0000;
        repeat (10) @(negedge clk);
        model_load(m, int'(val));
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0;
        m_got_a = 0; m_got_b = 0; m_got_op = 0;
    endtask

    initial begin
        int ops [10] = '{32, 34, 36, 37, 38, 39, 2, 3, 63, 17};
        int sel;
        rst_n = 1'b0;
        entrada = '0;
        {boton_acc, boton_op, boton_b, boton_a} = 4'b0000;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_model("reset");
        check("reset.zero_const", int'(zero), 1);

        // ADD overflow and SUB of equal operands
        press(4'b0001, 8'hF0);
        press(4'b0010, 8'h20);
        press(4'b0100, 8'h20);
        check_model("add_ovf");
        check("add_ovf.rdo_const", int'(rdo), 'h10);
        check("add_ovf.carry_const", int'(carry), 1);
        press(4'b0011, 8'h33);
        press(4'b0100, 8'h22);
        check_model("sub_eq");
        check("sub_eq.zero_const", int'(zero), 1);

        // Shifts, including amounts beyond the width
        press(4'b0001, 8'h90);
        press(4'b0010, 8'h02);
        press(4'b0100, 8'h03);
        check("sra2", int'(rdo), 'hE4);
        press(4'b0100, 8'h02);
        check("srl2", int'(rdo), 'h24);
        press(4'b0010, 8'h09);
        check_model("srl9");
        check("srl9.zero_const", int'(zero), 1);
        press(4'b0100, 8'h03);
        check("sra9", int'(rdo), 'hFF);

        // Accumulate chain
        press(4'b0011, 8'h01);
        press(4'b0100, 8'h20);
        check("acc0", int'(rdo), 2);
        press(4'b1000, 8'h00);
        check("acc1", int'(rdo), 3);
        press(4'b1000, 8'h00);
        check("acc2", int'(rdo), 4);
        press(4'b1000, 8'h00);
        check_model("acc3");
        press(4'b1001, 8'h77);
        check("a_wins_acc", int'(rdo), 'h78);

        // Bouncing button: rdo mirrors A via OR with B=0
        press(4'b0100, 8'h25);
        press(4'b0011, 8'h00);
        entrada = 8'h5A;
        for (int i = 0; i < 9; i++) begin
            boton_a = ~boton_a;
            @(negedge clk);
        end
        // last toggle left boton_a high at the previous negedge
        repeat (6) @(negedge clk);
        check("bounce_early", int'(rdo), 0);
        @(negedge clk);
        check("bounce_load", int'(rdo), 'h5A);
        entrada = 8'h11;
        repeat (20) @(negedge clk);
        boton_a = 1'b0;
        repeat (10) @(negedge clk);
        m_a = 'h5A;
        check_model("bounce_single");

        // Undefined opcode
        press(4'b0100, 8'h3F);
        check_model("undef");
        check("undef.zero_const", int'(zero), 1);

        // Asynchronous reset mid-cycle
        press(4'b0100, 8'h20);
        check("pre_reset", int'(rdo), 'h5A);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous a/b/op presses, valid one cycle after the load
        entrada = 8'h20;
        {boton_op, boton_b, boton_a} = 3'b111;
        repeat (6) @(negedge clk);
        check("simul.valid_early", int'(valid), 0);
        @(negedge clk);
        check("simul.valid_rise", int'(valid), 1);
        check("simul.rdo_old", int'(rdo), 0);
        @(negedge clk);
        check("simul.rdo", int'(rdo), 'h40);
        {boton_op, boton_b, boton_a} = 3'b000;
        repeat (10) @(negedge clk);
        model_load(4'b0111, 'h20);
        check_model("simul");

        // Randomized operations against the model
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: press(4'b0001, 8'($urandom));
                1: press(4'b0010, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom));
                2: press(4'b0100, 8'(ops[$urandom_range(0, 9)]));
                default: press(4'b1000, 8'h00);
            endcase
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
